// File: rtl/seq_mult_32bit.sv
// Shift-add 32x32 unsigned multiplier: done pulses 33 cycles after the accepting edge, 34-cycle occupancy.
// No backpressure: start is dropped while busy; product holds until the next accepted start.

module adder_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'h0, cin};

endmodule

module seq_mult_32bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [63:0] p;
  logic [31:0] a_r;
  logic [5:0]  cnt;

  logic [31:0] addend;
  logic [31:0] psum;
  logic        pcarry;

  // Multiplier LSB selects whether this step adds the multiplicand.
  assign addend = p[0] ? a_r : 32'h0;

  adder_32bit u_adder (
    .a    (p[63:32]),
    .b    (addend),
    .cin  (1'b0),
    .sum  (psum),
    .cout (pcarry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      p     <= 64'h0;
      a_r   <= 32'h0;
      cnt   <= 6'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_r   <= a;
            p     <= {32'h0, b};
            cnt   <= 6'd0;
            state <= RUN;
          end
        end
        RUN: begin
          // Carry lands in bit 63, so the shift never loses a product bit.
          p   <= {pcarry, psum, p[31:1]};
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy    = (state == RUN) || (state == DONE);
  assign done    = (state == DONE);
  assign product = p;

endmodule

// File: tb/tb_seq_mult_32bit.sv
// Scoreboard bench for seq_mult_32bit: expected products queued at start, compared at done.

module tb_seq_mult_32bit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int          checks;
  int          errors;
  logic [63:0] sb[$];
  logic [63:0] last_prod;

  seq_mult_32bit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Caller is at a negedge with the DUT idle. inj > 0 pulses a stray start in that RUN cycle.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input int inj, input string name);
    int          lat;
    logic [63:0] exp_p;
    checks++;
    if (busy !== 1'b0 || product !== last_prod) begin
      errors++;
      $display("FAIL %s idle_before_start: busy=%b product=%h, want busy=0 product=%h", name, busy, product, last_prod);
    end
    a     = av;
    b     = bv;
    start = 1'b1;
    sb.push_back(64'(av) * 64'(bv));
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    lat   = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL %s busy_after_start: busy=%b done=%b, want busy=1 done=0", name, busy, done);
        end
      end
      if (inj > 0 && n == inj) begin
        start = 1'b1;
        a     = 32'd2;
        b     = 32'd2;
      end else if (inj > 0 && n == inj + 1) begin
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
      end
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat != 33) begin
      errors++;
      $display("FAIL %s latency: done seen at cycle %0d, want 33 (0 = timeout)", name, lat);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: queue empty at done", name);
      exp_p = 64'h0;
    end else begin
      exp_p = sb.pop_front();
      if (product !== exp_p) begin
        errors++;
        $display("FAIL %s product: got %h, want %h", name, product, exp_p);
      end
    end
    last_prod = exp_p;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || product !== exp_p) begin
      errors++;
      $display("FAIL %s after_done: done=%b busy=%b product=%h, want 0 0 %h", name, done, busy, product, exp_p);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 64'h0) begin
      errors++;
      $display("FAIL reset_values: busy=%b done=%b product=%h, want 0 0 0", busy, done, product);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 64'h0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b product=%h, want 0 0 0", busy, done, product);
    end
  endtask

  task automatic test_basic();
    run_op(32'd3, 32'd5, 0, "basic_3x5");
    checks++;
    if (product !== 64'h0000_0000_0000_000F) begin
      errors++;
      $display("FAIL basic_literal: got %h, want 000000000000000f", product);
    end
  endtask

  task automatic test_max();
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "max_operands");
    checks++;
    if (product !== 64'hFFFF_FFFE_0000_0001) begin
      errors++;
      $display("FAIL max_literal: got %h, want fffffffe00000001", product);
    end
  endtask

  task automatic test_zero();
    run_op(32'h1234_5678, 32'h0, 0, "zero_b");
    run_op(32'h0, 32'hDEAD_BEEF, 0, "zero_a");
  endtask

  task automatic test_ignore_start();
    run_op(32'd7, 32'd9, 10, "ignore_start");
    checks++;
    if (product !== 64'd63) begin
      errors++;
      $display("FAIL ignore_literal: got %0d, want 63", product);
    end
    repeat (40) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL ignore_no_second_op: done=%b busy=%b, want 0 0", done, busy);
        break;
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    a     = 32'd100;
    b     = 32'd200;
    start = 1'b1;
    sb.push_back(64'd20000);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (16) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_busy_before: busy=%b, want 1", busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 64'h0) begin
      errors++;
      $display("FAIL abort_async: busy=%b done=%b product=%h, want 0 0 0", busy, done, product);
    end
    sb.delete();
    last_prod = 64'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_done: %0d active cycles after abort, want 0", seen);
    end
    run_op(32'd100, 32'd200, 0, "after_abort");
  endtask

  task automatic test_back_to_back();
    run_op(32'h0000_1234, 32'h0000_0010, 0, "b2b_first");
    run_op(32'h8000_0000, 32'd2, 0, "b2b_second");
    checks++;
    if (product !== 64'h0000_0001_0000_0000) begin
      errors++;
      $display("FAIL b2b_literal: got %h, want 0000000100000000", product);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      run_op($urandom, $urandom, 0, "random");
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    last_prod = 64'h0;
    rst_n     = 1'b0;
    start     = 1'b0;
    a         = 32'h0;
    b         = 32'h0;
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mult_32bit.md
SEQ_MULT_32BIT -- requirements
Module: seq_mult_32bit

Interface
REQ-001 Parameters: none; datapath fixed at 32-bit operands and 64-bit product.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request pulse; sampled on rising clk edge.
REQ-005 a  input  32  multiplicand, unsigned; sampled only when start is accepted.
REQ-006 b  input  32  multiplier, unsigned; sampled only when start is accepted.
REQ-007 busy  output  1  high while an operation is in progress.
REQ-008 done  output  1  one-cycle pulse marking a valid product.
REQ-009 product  output  64  unsigned a*b result; held stable until the next accepted start.

Function
REQ-010 FSM states SHALL be IDLE, RUN and DONE, and the design SHALL use no other reachable states.
REQ-011 IDLE with start=1 SHALL accept the request: latch A_r=a, load P={32'h0,b}, clear 6-bit cnt, and go to RUN.
REQ-012 IDLE with start=0 SHALL hold all registers.
REQ-013 Each RUN cycle SHALL compute {c,s}=P[63:32]+(P[0] ? A_r : 0) and then load P={c,s,P[31:1]}.
REQ-014 The partial-sum add SHALL use one adder_32bit instance (a=P[63:32], b=gated A_r, cin=0); cout SHALL feed c.
REQ-015 cnt SHALL increment once per RUN cycle; after the 32nd RUN cycle (cnt==31 at edge) the FSM SHALL go to DONE.
REQ-016 DONE SHALL last exactly one cycle with done=1, and the FSM SHALL then return to IDLE.
REQ-017 Latency: with start accepted at edge E0, done SHALL be high in the cycle after edge E0+32 (33rd cycle); total occupancy SHALL be 34 cycles including the IDLE return.
REQ-018 product SHALL be driven from P, and P SHALL be frozen in DONE and IDLE until the next accepted start.
REQ-019 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-020 start asserted in RUN or DONE SHALL be ignored, with no queueing and no effect on a, b or P.
REQ-021 start asserted in the IDLE cycle directly after DONE SHALL be accepted normally, which permits back-to-back operations every 34 cycles.
REQ-022 Arithmetic SHALL be unsigned with no overflow possible: a 64-bit result is exact, and the carry c is never dropped.
REQ-023 a or b changing while busy SHALL have no effect on the result.

Reset
REQ-024 While rst_n=0, and immediately on its assertion regardless of clk, the design SHALL drive state=IDLE, P=0, A_r=0, cnt=0, busy=0, done=0, product=64'h0.
REQ-025 Reset asserted mid-RUN SHALL abort the operation with no done pulse, and the outputs SHALL take the values of REQ-024.
REQ-026 After rst_n deasserts, the first accepted start SHALL be on the first rising edge with start=1.

Verification
REQ-027 a=3, b=5, start pulse -> busy high next cycle; done=1 exactly in the 33rd cycle after the start edge; product=64'h0000_0000_0000_000F.
REQ-028 a=32'hFFFF_FFFF, b=32'hFFFF_FFFF -> product=64'hFFFF_FFFE_0000_0001, which exercises the carry into bit 63.
REQ-029 a=32'h1234_5678, b=0, then a=0, b=32'hDEAD_BEEF -> both products=64'h0, each taking the full 33-cycle latency.
REQ-030 With a=7, b=9 in RUN, pulse start with a=2, b=2 at cycle 10 -> pulse ignored; product=64'd63; single done pulse.
REQ-031 Pull rst_n low at RUN cycle 16 of a=100, b=200 -> busy=0, done=0, product=0 asynchronously; no done pulse follows; a new start with a=100, b=200 -> product=64'd20000.
REQ-032 Back-to-back: start in the IDLE cycle after done with a=32'h8000_0000, b=2 -> product=64'h0000_0001_0000_0000; the first product stays stable until that start is accepted.
